// File: rtl/caliptra_log_fifo.sv
// caliptra_log_fifo: byte log FIFO drained by the host through a two-register APB slave
module caliptra_log_fifo #(
  parameter int DEPTH_LOG2 = 13
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic [7:0]  fifo_char,
  input  logic        fifo_write_en,
  input  logic        s_apb_psel,
  input  logic        s_apb_penable,
  input  logic        s_apb_pwrite,
  input  logic [3:0]  s_apb_paddr,
  input  logic [31:0] s_apb_pwdata,
  output logic [31:0] s_apb_prdata,
  output logic        s_apb_pready,
  output logic        s_apb_pslverr
);
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] count;
  logic overflow, rd_valid;
  logic empty, full, setup, access, sel_data, sel_stat, pop, push_ok, ovf_set, ovf_clr;
  logic [31:0] status;
  logic unused_ok;
  assign empty = count == '0;
  assign full = count[DEPTH_LOG2];
  assign setup = s_apb_psel & ~s_apb_penable;
  assign access = s_apb_psel & s_apb_penable;
  assign sel_data = s_apb_paddr[3:2] == 2'd0;
  assign sel_stat = s_apb_paddr[3:2] == 2'd1;
  assign s_apb_pready = 1'b1;
  assign s_apb_pslverr = access & (s_apb_paddr[3] | (sel_data & s_apb_pwrite));
  // A pop only completes when the preceding SETUP saw a byte available
  assign pop = access & sel_data & ~s_apb_pwrite & rd_valid;
  assign push_ok = fifo_write_en & (~full | pop);
  assign ovf_set = fifo_write_en & ~push_ok;
  assign ovf_clr = access & sel_stat & s_apb_pwrite & s_apb_pwdata[18];
  assign status = {13'b0, overflow, full, empty, 16'(count)};
  assign unused_ok = ^{s_apb_pwdata[31:19], s_apb_pwdata[17:0], s_apb_paddr[1:0]};
  // Byte storage; never read and written at the same address in one cycle
  always_ff @(posedge core_clk)
    if (push_ok) mem[wp] <= fifo_char;
  // Pointers, occupancy, sticky overflow and the registered read path
  always_ff @(posedge core_clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      s_apb_prdata <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(push_ok);
      rp <= rp + DEPTH_LOG2'(pop);
      count <= count + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop);
      overflow <= ovf_set | (overflow & ~ovf_clr);
      rd_valid <= setup & sel_data & ~s_apb_pwrite & ~empty;
      if (setup)
        s_apb_prdata <= sel_data ? {23'b0, ~empty, empty ? 8'h00 : mem[rp]} : sel_stat ? status : 32'h0;
    end
endmodule

// File: tb/tb_caliptra_log_fifo.sv
// tb_caliptra_log_fifo: scoreboard bench for the APB log FIFO (depth 16)
module tb_caliptra_log_fifo;
  logic core_clk = 0, rst = 1;
  logic [7:0] fifo_char = 0;
  logic fifo_write_en = 0;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [3:0] paddr = 0;
  logic [31:0] pwdata = 0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic peek = 0, done = 0;
  int total = 0, bad = 0;

  typedef struct {
    logic chk;
    logic [31:0] d;
    logic e;
  } exp_t;
  exp_t q[$];

  caliptra_log_fifo #(.DEPTH_LOG2(4)) dut (
    .core_clk(core_clk), .rst(rst), .fifo_char(fifo_char), .fifo_write_en(fifo_write_en),
    .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_prdata(prdata), .s_apb_pready(pready), .s_apb_pslverr(pslverr)
  );

  always #5 core_clk = ~core_clk;

  // Monitor: compare every ACCESS (or requested idle peek) against the next expectation
  always @(negedge core_clk) begin
    if ((psel && penable) || peek) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access: no expectation queued, prdata=%h pslverr=%b", prdata, pslverr);
      end else begin
        exp_t x;
        x = q.pop_front();
        if ((x.chk && prdata !== x.d) || pslverr !== x.e || pready !== 1'b1) begin
          bad++;
          $display("FAIL apb t=%0t: got prdata=%h pslverr=%b pready=%b, want prdata=%h pslverr=%b (data checked=%b)",
                   $time, prdata, pslverr, pready, x.d, x.e, x.chk);
        end
      end
    end
    if (done) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL leftover: %0d expectations never matched, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic push(input logic [7:0] c);
    fifo_write_en = 1;
    fifo_char = c;
    @(posedge core_clk); #1;
    fifo_write_en = 0;
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     input logic chk, input logic [31:0] ed, input logic ee,
                     input logic pe, input logic [7:0] pc);
    q.push_back('{chk: chk, d: ed, e: ee});
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge core_clk); #1;
    penable = 1; fifo_write_en = pe; fifo_char = pc;
    @(posedge core_clk); #1;
    psel = 0; penable = 0; fifo_write_en = 0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ed);
    apb(0, a, 0, 1, ed, 0, 0, 0);
  endtask

  task automatic peek_prdata(input logic [31:0] ed);
    q.push_back('{chk: 1, d: ed, e: 0});
    peek = 1;
    @(posedge core_clk); #1;
    peek = 0;
  endtask

  initial begin
    repeat (2) @(posedge core_clk);
    #1 rst = 0;
    peek_prdata(32'h0);
    rd(4'h4, 32'h0001_0000);
    rd(4'h0, 32'h0000_0000);
    rd(4'h4, 32'h0001_0000);
    push(8'h48); push(8'h69); push(8'h0A);
    rd(4'h0, 32'h148); rd(4'h0, 32'h169); rd(4'h0, 32'h10A);
    rd(4'h4, 32'h0001_0000);
    for (int i = 0; i <= 16; i++) push(8'(i));
    rd(4'h4, 32'h0006_0010);
    for (int i = 0; i < 16; i++) rd(4'h0, 32'h100 | i);
    rd(4'h4, 32'h0005_0000);
    apb(1, 4'h4, 32'h0004_0000, 0, 0, 0, 0, 0);
    rd(4'h4, 32'h0001_0000);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    rd(4'h4, 32'h0002_0010);
    apb(0, 4'h0, 0, 1, 32'h120, 0, 1, 8'hAA);
    rd(4'h4, 32'h0002_0010);
    for (int i = 1; i < 16; i++) rd(4'h0, 32'h100 | (32'h20 + i));
    rd(4'h0, 32'h1AA);
    rd(4'h4, 32'h0001_0000);
    push(8'h77);
    apb(1, 4'h0, 32'h55, 0, 0, 1, 0, 0);
    rd(4'h4, 32'h0000_0001);
    rd(4'h0, 32'h177);
    apb(0, 4'h8, 0, 1, 32'h0, 1, 0, 0);
    apb(0, 4'hC, 0, 1, 32'h0, 1, 0, 0);
    apb(1, 4'h8, 32'h0004_0000, 0, 0, 1, 0, 0);
    rd(4'h4, 32'h0001_0000);
    push(8'h30);
    for (int i = 0; i < 40; i++)
      apb(0, 4'h0, 0, 1, 32'h100 | (32'h30 + i), 0, i < 39, 8'(8'h31 + i));
    rd(4'h4, 32'h0001_0000);
    push(8'h5A); push(8'h5B);
    psel = 1; penable = 0; pwrite = 0; paddr = 4'h0;
    @(posedge core_clk); #1;
    psel = 0; rst = 1;
    @(posedge core_clk); #1;
    rst = 0;
    peek_prdata(32'h0);
    rd(4'h4, 32'h0001_0000);
    rd(4'h0, 32'h0);
    repeat (3) @(posedge core_clk);
    #1 done = 1;
  end
endmodule
